// File: rtl/l1a_fifo_reader.sv
// l1a_fifo_reader
// ---------------
// Drains entries from an L1A FIFO and packs them into framed 16-bit words
// for the DAQ link. A frame is a header word, one low and one high half-word
// per FIFO entry (up to MAX_ENTRIES entries), and a trailer carrying the
// entry count. Frames are numbered by frame_seq, which counts completed
// frames modulo 4096.
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   enable     in   1   permits a new frame to start (checked only in IDLE)
//   fifo_dout  in  30   FIFO read data, valid the cycle after a read edge
//   fifo_empty in   1   registered FIFO empty flag
//   fifo_ren   out  1   FIFO read enable (one-cycle pulse per entry)
//   daq_data   out 16   output word
//   daq_valid  out  1   daq_data is valid
//   daq_ready  in   1   sink accepts the word
//   daq_last   out  1   marks the trailer word
//   busy       out  1   state is not IDLE
//   frame_seq  out 12   count of completed frames
//   dbg_state  out  3   current FSM state encoding, for observation
//
// Handshake: a word transfers on a rising edge where daq_valid=1 and
// daq_ready=1. While daq_valid=1 and daq_ready=0 the state and entry
// register hold, so daq_data and daq_last are stable until accepted.

module l1a_fifo_reader #(
    parameter int MAX_ENTRIES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [29:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_ren,
    output logic [15:0] daq_data,
    output logic        daq_valid,
    input  logic        daq_ready,
    output logic        daq_last,
    output logic        busy,
    output logic [11:0] frame_seq,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        REQ  = 3'd2,
        CAPT = 3'd3,
        LO   = 3'd4,
        HI   = 3'd5,
        TRL  = 3'd6
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_ENTRIES);

    state_t      state_q, state_d;
    logic [29:0] entry_q, entry_d;
    logic [3:0]  entry_cnt_q, entry_cnt_d;
    logic [11:0] frame_seq_q, frame_seq_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            entry_cnt_q <= '0;
            frame_seq_q <= '0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            entry_cnt_q <= entry_cnt_d;
            frame_seq_q <= frame_seq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        entry_cnt_d = entry_cnt_q;
        frame_seq_d = frame_seq_q;
        fifo_ren    = 1'b0;
        daq_valid   = 1'b0;
        daq_last    = 1'b0;
        daq_data    = 16'h0000;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d     = HDR;
                    entry_cnt_d = 4'd0;
                end
            end
            HDR: begin
                daq_valid = 1'b1;
                daq_data  = {4'hA, frame_seq_q};
                if (daq_ready) state_d = REQ;
            end
            REQ: begin
                // Emptiness was already checked in IDLE/HI with a settled flag;
                // the gate is a last guard against reading an empty FIFO.
                fifo_ren = !fifo_empty;
                state_d  = CAPT;
            end
            CAPT: begin
                // Read data appears the cycle after the read edge, i.e. now.
                entry_d     = fifo_dout;
                entry_cnt_d = entry_cnt_q + 4'd1;
                state_d     = LO;
            end
            LO: begin
                daq_valid = 1'b1;
                daq_data  = {1'b0, entry_q[14:0]};
                if (daq_ready) state_d = HI;
            end
            HI: begin
                daq_valid = 1'b1;
                daq_data  = {1'b1, entry_q[29:15]};
                if (daq_ready) begin
                    if ((entry_cnt_q == MAX_CNT) || fifo_empty) state_d = TRL;
                    else                                        state_d = REQ;
                end
            end
            TRL: begin
                daq_valid = 1'b1;
                daq_last  = 1'b1;
                daq_data  = {4'hE, 8'h00, entry_cnt_q};
                if (daq_ready) begin
                    frame_seq_d = frame_seq_q + 12'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign frame_seq = frame_seq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_l1a_fifo_reader.sv
// tb_l1a_fifo_reader
// ------------------
// Bench for l1a_fifo_reader. A queue-based L1A FIFO model feeds the DUT;
// each batch of entries is turned into the expected word stream (frames of
// up to MAX_ENTRIES entries) by a simple framing model, and a monitor pops
// that stream on every accepted word. Sink readiness is randomized in most
// phases.

module tb_l1a_fifo_reader;

    localparam int MAX_ENTRIES = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_LO   = 3'd4;
    localparam logic [2:0] ST_HI   = 3'd5;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [29:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] daq_data;
    logic        daq_valid;
    logic        daq_ready;
    logic        daq_last;
    logic        busy;
    logic [11:0] frame_seq;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [29:0] fifo_q[$];
    logic [16:0] exp_q[$];
    int          seq_m = 0;
    int          ren_count = 0;
    int          exp_ren = 0;
    bit          rand_ready = 0;
    bit          idle_watch = 0;
    bit          prev_stall = 0;
    logic [16:0] prev_word = '0;

    l1a_fifo_reader #(.MAX_ENTRIES(MAX_ENTRIES)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .daq_data   (daq_data),
        .daq_valid  (daq_valid),
        .daq_ready  (daq_ready),
        .daq_last   (daq_last),
        .busy       (busy),
        .frame_seq  (frame_seq),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- L1A FIFO model ----------------
    // Read data is registered on the read edge; the empty flag is registered
    // and reflects the queue contents after that edge.
    always @(posedge clk) begin
        if (fifo_ren) begin
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            else begin
                errors++;
                $display("FAIL read_of_empty_fifo observed=1 expected=0");
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // ---------------- sink readiness driver ----------------
    initial begin
        daq_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            daq_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(daq_valid), 32'd1);
                check("stall_word_held", 32'({daq_last, daq_data}), 32'(prev_word));
            end
            if (daq_valid && daq_ready) begin
                if (exp_q.size() > 0)
                    check("word", 32'({daq_last, daq_data}), 32'(exp_q.pop_front()));
                else
                    check("unexpected_word", 32'({daq_last, daq_data}), 32'hDEAD_BEEF);
            end
            if (idle_watch) begin
                check("gated_busy", 32'(busy), 32'd0);
                check("gated_ren", 32'(fifo_ren), 32'd0);
            end
            if (fifo_ren) ren_count++;
            prev_stall = daq_valid && !daq_ready;
            prev_word  = {daq_last, daq_data};
        end
    end

    // ---------------- framing model ----------------
    // Entries pushed together while the reader is idle form frames of
    // MAX_ENTRIES entries, the last frame taking the remainder.
    task automatic push_batch(input int n, input logic [29:0] first_val, input bit use_first);
        int   idx;
        int   cnt;
        int   ent;
        int   batch[$];
        for (int i = 0; i < n; i++) begin
            logic [29:0] v;
            v = (i == 0 && use_first) ? first_val : 30'($urandom);
            batch.push_back(int'(v));
            fifo_q.push_back(v);
        end
        exp_ren += n;
        idx = 0;
        while (idx < n) begin
            cnt = (n - idx > MAX_ENTRIES) ? MAX_ENTRIES : n - idx;
            exp_q.push_back(17'(16'hA000 + seq_m));
            for (int k = 0; k < cnt; k++) begin
                ent = batch[idx + k];
                exp_q.push_back(17'(ent % 32768));
                exp_q.push_back(17'(32768 + ent / 32768));
            end
            exp_q.push_back(17'(65536 + 16'hE000 + cnt));
            seq_m = (seq_m + 1) % 4096;
            idx += cnt;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (dbg_state == s) break;
            @(negedge clk);
        end
        check(tag, 32'(dbg_state), 32'(s));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && fifo_q.size() == 0) break;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_reads"}, 32'(ren_count), 32'(exp_ren));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ren_before;
        reset      = 1'b1;
        enable     = 1'b0;
        fifo_dout  = '0;
        fifo_empty = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_ren", 32'(fifo_ren), 32'd0);
        check("rst_valid", 32'(daq_valid), 32'd0);
        check("rst_last", 32'(daq_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(daq_data), 32'd0);
        check("rst_seq", 32'(frame_seq), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single entry: A000, 2AAA, D555, E001(last)
        enable = 1'b1;
        push_batch(1, 30'h2AAAAAAA, 1);
        wait_state(ST_HDR, "single_hdr_state");
        check("single_hdr", 32'(daq_data), 32'hA000);
        wait_drain("single");
        check("single_seq", 32'(frame_seq), 32'd1);

        // Six entries split 4 + 2, with backpressure
        rand_ready = 1;
        push_batch(6, '0, 0);
        wait_drain("split");
        check("split_seq", 32'(frame_seq), 32'd3);

        // Random batches with backpressure
        for (int b = 0; b < 6; b++) begin
            push_batch(int'($urandom_range(1, 9)), '0, 0);
            wait_drain("rand_batch");
        end

        // Enable gating: no reads while disabled
        enable = 1'b0;
        @(negedge clk);
        ren_before = ren_count;
        idle_watch = 1;
        push_batch(1, '0, 0);
        repeat (20) @(negedge clk);
        idle_watch = 0;
        check("gated_no_reads", 32'(ren_count), 32'(ren_before));
        enable = 1'b1;
        wait_drain("gated_release");

        // Enable dropped during LO: current frame still finishes
        push_batch(6, '0, 0);
        wait_state(ST_LO, "drop_lo_state");
        enable = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_words_left", 32'(exp_q.size()), 32'd6);
        check("drop_fifo_left", 32'(fifo_q.size()), 32'd2);
        enable = 1'b1;
        wait_drain("drop_release");

        // Reset during HI abandons the frame
        push_batch(3, '0, 0);
        wait_state(ST_HI, "rst_mid_state");
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(daq_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_seq", 32'(frame_seq), 32'd0);
        check("rst_mid_last", 32'(daq_last), 32'd0);
        check("rst_mid_ren", 32'(fifo_ren), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        seq_m     = 0;
        ren_count = 0;
        exp_ren   = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_batch(2, '0, 0);
        wait_state(ST_HDR, "post_rst_hdr_state");
        check("post_rst_hdr", 32'(daq_data), 32'hA000);
        wait_drain("post_rst");

        // frame_seq wrap: bring the count back to zero through 4096 frames
        rand_ready = 0;
        for (int f = 0; f < 4095; f++) begin
            push_batch(1, '0, 0);
            wait_drain("wrap_frame");
        end
        check("wrap_seq", 32'(frame_seq), 32'd0);
        push_batch(1, '0, 0);
        wait_state(ST_HDR, "wrap_hdr_state");
        check("wrap_hdr", 32'(daq_data), 32'hA000);
        wait_drain("wrap_last");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1a_fifo_reader.md
L1A_FIFO_READER -- requirements
Module: l1a_fifo_reader

Interface
REQ-001 SHALL have parameter MAX_ENTRIES, default 4, giving the maximum number of FIFO entries per frame (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: permits a new frame to start.
REQ-005 SHALL have port fifo_dout, input, 30 bits: L1A FIFO read data, valid the cycle after a read edge.
REQ-006 SHALL have port fifo_empty, input, 1 bit: registered L1A FIFO empty flag.
REQ-007 SHALL have port fifo_ren, output, 1 bit: L1A FIFO read enable.
REQ-008 SHALL have port daq_data, output, 16 bits: output word.
REQ-009 SHALL have port daq_valid, output, 1 bit: daq_data is valid.
REQ-010 SHALL have port daq_ready, input, 1 bit: the sink accepts the word.
REQ-011 SHALL have port daq_last, output, 1 bit: marks the trailer word.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port frame_seq, output, 12 bits: count of completed frames.

Function
REQ-014 SHALL implement the states IDLE, HDR, REQ, CAPT, LO, HI and TRL.
REQ-015 A word SHALL transfer on a rising edge where daq_valid=1 and daq_ready=1; daq_data and daq_last SHALL stay stable while daq_valid=1 and daq_ready=0.
REQ-016 IDLE: with enable=1 and fifo_empty=0, the next state SHALL be HDR and entry_cnt SHALL clear to 0; otherwise the block SHALL stay in IDLE.
REQ-017 HDR SHALL drive daq_valid=1 and daq_data={4'hA, frame_seq}, and SHALL go to REQ on transfer.
REQ-018 REQ SHALL assert fifo_ren=1 for exactly one cycle, gated by !fifo_empty, then go to CAPT; fifo_ren SHALL be 0 in every other state.
REQ-019 CAPT SHALL latch fifo_dout into a 30-bit entry register, increment entry_cnt (4 bits), drive daq_valid=0, and go to LO.
REQ-020 LO SHALL drive daq_data={1'b0, entry[14:0]} and SHALL go to HI on transfer.
REQ-021 HI SHALL drive daq_data={1'b1, entry[29:15]}.
REQ-022 On HI transfer, the next state SHALL be TRL if entry_cnt==MAX_ENTRIES or fifo_empty=1, else REQ.
REQ-023 TRL SHALL drive daq_data={4'hE, 8'h00, entry_cnt} with daq_last=1.
REQ-024 On TRL transfer, frame_seq SHALL increment modulo 4096 and the next state SHALL be IDLE.
REQ-025 enable going low mid-frame SHALL NOT abort the frame; it only blocks the next IDLE->HDR.
REQ-026 The fifo_empty sampled in IDLE and HI SHALL reflect all prior reads; the block SHALL NOT issue a read to an empty FIFO.
REQ-027 Minimum read spacing SHALL be 4 cycles (REQ, CAPT, LO, HI), so fifo_empty is always settled when sampled.
REQ-028 daq_valid SHALL be 1 only in HDR, LO, HI and TRL.
REQ-029 daq_last SHALL be 1 only in TRL.
REQ-030 frame_seq SHALL wrap from 4095 to 0.

Reset
REQ-031 While reset=1, the state SHALL be IDLE and fifo_ren, daq_valid, daq_last and busy SHALL be 0.
REQ-032 While reset=1, daq_data, frame_seq, entry_cnt and the entry register SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately with no trailer; the entry in flight is lost.
REQ-034 The first frame after reset release SHALL carry header 16'hA000.

Verification
REQ-035 Single entry: FIFO holds 30'h2AAAAAAA, daq_ready=1 -> words A000, 2AAA (lo), D555 (hi), E001 with last=1; fifo_ren pulses once; frame_seq becomes 1.
REQ-036 Split frames: FIFO holds 6 entries, MAX_ENTRIES=4 -> frame 0 carries 4 entries (trailer E004), then frame 1 (header A001) carries 2 entries (trailer E002).
REQ-037 Backpressure: daq_ready toggled pseudo-randomly -> no word lost or duplicated, daq_data stable while stalled, exactly one fifo_ren per entry.
REQ-038 Reset mid-frame: reset asserted during HI -> daq_valid=0, busy=0 and frame_seq=0 immediately; the next frame has header A000.
REQ-039 Enable gating: enable=0 with a non-empty FIFO -> no fifo_ren and busy stays 0; enable dropped during LO -> the current frame still completes with its trailer.
REQ-040 Wrap: frame_seq preset by running 4096 frames -> the header after frame 4095 is A000.
